mem_access_stage: RTL and testbench

//  Memory stage of the 32-bit RISC pipeline, directly upstream of writeBack. Takes the EX result
//  (ALUresult as address, store data, control bits); runs a req/ack handshake with data memory;

---
 rtl/mem_access_stage_if.sv | 22 ++
 rtl/mem_access_stage.sv | 175 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// Data-memory bus between the memory-access stage (master) and data memory (slave):
// request/ack handshake with word address, write enable, store data and load data.
interface mem_access_stage_if #(
    parameter int DATA_W = 32
) ();
    logic              dmemReq;
    logic              dmemWe;
    logic [DATA_W-1:0] dmemAddr;
    logic [DATA_W-1:0] dmemWdata;
    logic [DATA_W-1:0] dmemRdata;
    logic              dmemAck;

    modport master (
        output dmemReq, dmemWe, dmemAddr, dmemWdata,
        input  dmemRdata, dmemAck
    );

    modport slave (
        input  dmemReq, dmemWe, dmemAddr, dmemWdata,
        output dmemRdata, dmemAck
    );
endinterface

// File: rtl/mem_access_stage.sv
// Memory stage of the 32-bit RISC pipeline: req/ack access to data memory with timeout abort,
// registered results for writeBack. Optional `MISALIGN_CHECK_EN aborts unaligned memory ops.
module mem_access_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  exValid,
    output logic                  exReady,
    input  logic [DATA_W-1:0]     ALUresult,
    input  logic [DATA_W-1:0]     writeData,
    input  logic                  memRead,
    input  logic                  memWrite,
    input  logic                  memToReg,
    input  logic                  regWrite,
    input  logic [REG_ADDR_W-1:0] rd,
    mem_access_stage_if.master    dmem,
    output logic                  wbValid,
    output logic [DATA_W-1:0]     wbALUresult,
    output logic [DATA_W-1:0]     readData,
    output logic                  wbMemToReg,
    output logic                  wbRegWrite,
    output logic [REG_ADDR_W-1:0] wbRd,
    output logic                  busErr,
    output logic                  misaligned
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    function automatic logic [DATA_W-1:0] word_addr(input logic [DATA_W-1:0] a);
        return {a[DATA_W-1:2], 2'b00};
    endfunction

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic                    is_mem;
    logic                    mis_op;
    logic                    ld_p0;

    logic [DATA_W-1:0]       addr_p0;
    logic [DATA_W-1:0]       wdata_p0;
    logic [DATA_W-1:0]       alu_p0;
    logic                    we_p0;
    logic                    mtr_p0;
    logic                    rw_p0;
    logic [REG_ADDR_W-1:0]   rd_p0;

    logic                    vld_d;
    logic [DATA_W-1:0]       alu_d;
    logic [DATA_W-1:0]       rdat_d;
    logic                    mtr_d;
    logic                    rw_d;
    logic [REG_ADDR_W-1:0]   rd_d;
    logic                    berr_d;
    logic                    mis_d;

    assign is_mem = memRead | memWrite;
`ifdef MISALIGN_CHECK_EN
    assign mis_op = is_mem & (ALUresult[1:0] != 2'b00);
`else
    assign mis_op = 1'b0;
`endif

    assign exReady        = (state_q == IDLE);
    assign dmem.dmemReq   = (state_q == BUSY);
    assign dmem.dmemWe    = we_p0;
    assign dmem.dmemAddr  = addr_p0;
    assign dmem.dmemWdata = wdata_p0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ld_p0   = 1'b0;
        vld_d   = 1'b0;
        berr_d  = 1'b0;
        mis_d   = 1'b0;
        alu_d   = wbALUresult;
        rdat_d  = readData;
        mtr_d   = wbMemToReg;
        rw_d    = wbRegWrite;
        rd_d    = wbRd;
        case (state_q)
            IDLE: begin
                if (exValid) begin
                    cnt_d = '0;
                    if (is_mem && !mis_op) begin
                        state_d = BUSY;
                        ld_p0   = 1'b1;
                    end else begin
                        // Non-memory and rejected misaligned ops retire straight from the inputs.
                        vld_d  = 1'b1;
                        alu_d  = ALUresult;
                        rdat_d = '0;
                        mtr_d  = memToReg;
                        rw_d   = regWrite & ~mis_op;
                        rd_d   = rd;
                        mis_d  = mis_op;
                    end
                end
            end
            BUSY: begin
                if (dmem.dmemAck) begin
                    state_d = IDLE;
                    vld_d   = 1'b1;
                    alu_d   = alu_p0;
                    rdat_d  = we_p0 ? '0 : dmem.dmemRdata;
                    mtr_d   = mtr_p0;
                    rw_d    = rw_p0;
                    rd_d    = rd_p0;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    // Last allowed unacked cycle: abort and retire without a register write.
                    state_d = IDLE;
                    vld_d   = 1'b1;
                    alu_d   = alu_p0;
                    rdat_d  = '0;
                    mtr_d   = mtr_p0;
                    rw_d    = 1'b0;
                    rd_d    = rd_p0;
                    berr_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    // p0: request registers captured at accept; outputs: writeBack registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_p0     <= '0;
            wdata_p0    <= '0;
            alu_p0      <= '0;
            we_p0       <= 1'b0;
            mtr_p0      <= 1'b0;
            rw_p0       <= 1'b0;
            rd_p0       <= '0;
            wbValid     <= 1'b0;
            wbALUresult <= '0;
            readData    <= '0;
            wbMemToReg  <= 1'b0;
            wbRegWrite  <= 1'b0;
            wbRd        <= '0;
            busErr      <= 1'b0;
            misaligned  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            if (ld_p0) begin
                addr_p0  <= word_addr(ALUresult);
                wdata_p0 <= writeData;
                alu_p0   <= ALUresult;
                we_p0    <= memWrite;
                mtr_p0   <= memToReg;
                rw_p0    <= regWrite;
                rd_p0    <= rd;
            end
            wbValid     <= vld_d;
            wbALUresult <= alu_d;
            readData    <= rdat_d;
            wbMemToReg  <= mtr_d;
            wbRegWrite  <= rw_d;
            wbRd        <= rd_d;
            busErr      <= berr_d;
            misaligned  <= mis_d;
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: expected writeBack records queued at issue and
// compared whenever wbValid pulses. Build with +define+MISALIGN_CHECK_EN for the checked variant.
module tb_mem_access_stage;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int TIMEOUT    = 15;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] rdata;
        logic        mtr;
        logic        rw;
        logic [4:0]  rd;
        logic        berr;
        logic        mis;
    } wb_t;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  exValid;
    logic                  exReady;
    logic [DATA_W-1:0]     ALUresult;
    logic [DATA_W-1:0]     writeData;
    logic                  memRead;
    logic                  memWrite;
    logic                  memToReg;
    logic                  regWrite;
    logic [REG_ADDR_W-1:0] rd;
    logic                  wbValid;
    logic [DATA_W-1:0]     wbALUresult;
    logic [DATA_W-1:0]     readData;
    logic                  wbMemToReg;
    logic                  wbRegWrite;
    logic [REG_ADDR_W-1:0] wbRd;
    logic                  busErr;
    logic                  misaligned;

    int  n_checks = 0;
    int  n_fail   = 0;
    wb_t sb_q[$];

    mem_access_stage_if #(.DATA_W(DATA_W)) dmem ();

    mem_access_stage #(
        .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .exValid(exValid), .exReady(exReady),
        .ALUresult(ALUresult), .writeData(writeData), .memRead(memRead),
        .memWrite(memWrite), .memToReg(memToReg), .regWrite(regWrite), .rd(rd),
        .dmem(dmem), .wbValid(wbValid), .wbALUresult(wbALUresult), .readData(readData),
        .wbMemToReg(wbMemToReg), .wbRegWrite(wbRegWrite), .wbRd(wbRd),
        .busErr(busErr), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] alu, input logic [31:0] wd, input logic mr,
                        input logic mw, input logic mtr, input logic rw, input logic [4:0] r);
        check("exReady_pre", {31'd0, exReady}, 32'd1);
        exValid   = 1'b1;
        ALUresult = alu;
        writeData = wd;
        memRead   = mr;
        memWrite  = mw;
        memToReg  = mtr;
        regWrite  = rw;
        rd        = r;
        step();
    endtask

    task automatic idle();
        exValid  = 1'b0;
        memRead  = 1'b0;
        memWrite = 1'b0;
    endtask

    // Called in the first BUSY cycle; acks on request cycle ack_cycle.
    task automatic mem_wait(input int ack_cycle, input logic [31:0] d);
        for (int c = 1; c < ack_cycle; c++) begin
            check("req_hold", {31'd0, dmem.dmemReq}, 32'd1);
            check("busy_exReady", {31'd0, exReady}, 32'd0);
            step();
        end
        dmem.dmemAck   = 1'b1;
        dmem.dmemRdata = d;
        step();
        dmem.dmemAck   = 1'b0;
        dmem.dmemRdata = 32'hA5A5_A5A5;
        check("req_drop", {31'd0, dmem.dmemReq}, 32'd0);
        check("done_wbValid", {31'd0, wbValid}, 32'd1);
        check("done_exReady", {31'd0, exReady}, 32'd1);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (wbValid) begin
                if (sb_q.size() == 0) begin
                    check("wb_unexpected", {31'd0, wbValid}, 32'd0);
                end else begin
                    wb_t e;
                    e = sb_q.pop_front();
                    check("wb_alu",   wbALUresult, e.alu);
                    check("wb_rdata", readData, e.rdata);
                    check("wb_mtr",   {31'd0, wbMemToReg}, {31'd0, e.mtr});
                    check("wb_rw",    {31'd0, wbRegWrite}, {31'd0, e.rw});
                    check("wb_rd",    {27'd0, wbRd}, {27'd0, e.rd});
                    check("wb_berr",  {31'd0, busErr}, {31'd0, e.berr});
                    check("wb_mis",   {31'd0, misaligned}, {31'd0, e.mis});
                end
            end else if (busErr || misaligned) begin
                check("stray_pulse", {30'd0, busErr, misaligned}, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        reset          = 1'b1;
        exValid        = 1'b0;
        ALUresult      = '0;
        writeData      = '0;
        memRead        = 1'b0;
        memWrite       = 1'b0;
        memToReg       = 1'b0;
        regWrite       = 1'b0;
        rd             = '0;
        dmem.dmemAck   = 1'b0;
        dmem.dmemRdata = '0;
        step(); step();
        check("rst_exReady", {31'd0, exReady}, 32'd1);
        check("rst_req",     {31'd0, dmem.dmemReq}, 32'd0);
        check("rst_wbValid", {31'd0, wbValid}, 32'd0);
        check("rst_addr",    dmem.dmemAddr, 32'd0);
        check("rst_wbalu",   wbALUresult, 32'd0);
        reset = 1'b0;
        step();

        // Non-memory op, latency 1
        sb_q.push_back('{alu: 32'h10, rdata: 0, mtr: 0, rw: 1, rd: 3, berr: 0, mis: 0});
        send(32'h10, 32'h0, 0, 0, 0, 1, 5'd3);
        idle();
        check("nonmem_lat", {31'd0, wbValid}, 32'd1);
        check("nonmem_req", {31'd0, dmem.dmemReq}, 32'd0);
        step();
        check("nonmem_pulse", {31'd0, wbValid}, 32'd0);

        // Load, acked on the 4th request cycle; then accept right in the wbValid cycle
        sb_q.push_back('{alu: 32'h100, rdata: 32'hDEAD_BEEF, mtr: 1, rw: 1, rd: 7, berr: 0, mis: 0});
        send(32'h100, 32'h0, 1, 0, 1, 1, 5'd7);
        idle();
        check("ld_addr", dmem.dmemAddr, 32'h100);
        check("ld_we",   {31'd0, dmem.dmemWe}, 32'd0);
        mem_wait(4, 32'hDEAD_BEEF);
        sb_q.push_back('{alu: 32'h55, rdata: 0, mtr: 0, rw: 1, rd: 9, berr: 0, mis: 0});
        send(32'h55, 32'h0, 0, 0, 0, 1, 5'd9);
        idle();
        check("b2b_after_ld", {31'd0, wbValid}, 32'd1);
        step();

        // Store, ack on the first request cycle
        sb_q.push_back('{alu: 32'h204, rdata: 0, mtr: 0, rw: 0, rd: 0, berr: 0, mis: 0});
        send(32'h204, 32'h1234_5678, 0, 1, 0, 0, 5'd0);
        idle();
        check("st_we",    {31'd0, dmem.dmemWe}, 32'd1);
        check("st_wdata", dmem.dmemWdata, 32'h1234_5678);
        check("st_addr",  dmem.dmemAddr, 32'h204);
        mem_wait(1, 32'hFFFF_FFFF);
        step();

        // Ack while idle is ignored
        dmem.dmemAck = 1'b1;
        step();
        dmem.dmemAck = 1'b0;
        step();
        check("idle_ack", {31'd0, wbValid}, 32'd0);

        // Timeout abort
        sb_q.push_back('{alu: 32'h300, rdata: 0, mtr: 1, rw: 0, rd: 4, berr: 1, mis: 0});
        send(32'h300, 32'h0, 1, 0, 1, 1, 5'd4);
        idle();
        n = 0;
        while (dmem.dmemReq && n < 40) begin
            n++;
            step();
        end
        check("to_len",   n, TIMEOUT);
        check("to_berr",  {31'd0, busErr}, 32'd1);
        check("to_valid", {31'd0, wbValid}, 32'd1);
        step();
        check("to_pulse", {31'd0, busErr}, 32'd0);

        // Ack on the last allowed cycle wins over the timeout
        sb_q.push_back('{alu: 32'h304, rdata: 32'hCAFE_0001, mtr: 1, rw: 1, rd: 6, berr: 0, mis: 0});
        send(32'h304, 32'h0, 1, 0, 1, 1, 5'd6);
        idle();
        mem_wait(TIMEOUT, 32'hCAFE_0001);
        check("late_berr", {31'd0, busErr}, 32'd0);
        step();

        // Back-to-back non-memory ops
        sb_q.push_back('{alu: 32'h1, rdata: 0, mtr: 0, rw: 1, rd: 1, berr: 0, mis: 0});
        sb_q.push_back('{alu: 32'h2, rdata: 0, mtr: 0, rw: 0, rd: 2, berr: 0, mis: 0});
        send(32'h1, 32'h0, 0, 0, 0, 1, 5'd1);
        send(32'h2, 32'h0, 0, 0, 0, 0, 5'd2);
        idle();
        check("b2b_second", {31'd0, wbValid}, 32'd1);
        step();

        // Reset during BUSY discards the op
        send(32'h400, 32'h0, 1, 0, 1, 1, 5'd8);
        idle();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mrst_req",     {31'd0, dmem.dmemReq}, 32'd0);
        check("mrst_exReady", {31'd0, exReady}, 32'd1);
        check("mrst_wbValid", {31'd0, wbValid}, 32'd0);
        check("mrst_rw",      {31'd0, wbRegWrite}, 32'd0);
        dmem.dmemAck   = 1'b1;
        dmem.dmemRdata = 32'h1111_2222;
        step();
        dmem.dmemAck = 1'b0;
        step();
        check("mrst_lateack", {31'd0, wbValid}, 32'd0);

        // Misaligned load
`ifdef MISALIGN_CHECK_EN
        sb_q.push_back('{alu: 32'h103, rdata: 0, mtr: 1, rw: 0, rd: 5, berr: 0, mis: 1});
        send(32'h103, 32'h0, 1, 0, 1, 1, 5'd5);
        idle();
        check("mis_req",   {31'd0, dmem.dmemReq}, 32'd0);
        check("mis_flag",  {31'd0, misaligned}, 32'd1);
        check("mis_valid", {31'd0, wbValid}, 32'd1);
`else
        sb_q.push_back('{alu: 32'h103, rdata: 32'h0BAD_F00D, mtr: 1, rw: 1, rd: 5, berr: 0, mis: 0});
        send(32'h103, 32'h0, 1, 0, 1, 1, 5'd5);
        idle();
        check("mis_addr", dmem.dmemAddr, 32'h100);
        check("mis_req",  {31'd0, dmem.dmemReq}, 32'd1);
        mem_wait(2, 32'h0BAD_F00D);
`endif
        step();
        step();

        check("sb_drain", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
